cipher_stream_ctrl: RTL and testbench

//  Byte-stream front/back end for the Twofish datapath core. Packs an 8-bit valid/ready input

---
 rtl/cipher_pkg.sv | 23 ++
 rtl/byte_packer.sv | 65 ++++++
 rtl/cipher_stream_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_cipher_stream_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cipher_pkg
// Purpose  : Shared types and constants for the Twofish byte-stream
//            controller (controller FSM encoding, group/key sizes).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cipher_pkg;

  // Controller FSM states.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } ctrl_state_t;

  localparam int BLOCK_BYTES = 16;
  localparam int KEY_BITS    = 128;

endpackage : cipher_pkg
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_packer
// Purpose  : Packs a byte stream into a BYTES-wide word, first byte landing
//            in the most significant position. Flags the shift that
//            completes a group.
// Ports    : clk_i      - clock
//            rst_i      - asynchronous active-high reset
//            clear_i    - discard the partial group (count back to 0)
//            shift_i    - accept byte_i this cycle
//            byte_i     - incoming byte
//            word_o     - complete word, valid while complete_o is high
//            cnt_o      - bytes held in the current partial group
//            complete_o - this shift delivers the last byte of a group
// Revision : 1.0 - initial release
// ============================================================================
module byte_packer #(
  parameter int BYTES = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       shift_i,
  input  logic [7:0]                 byte_i,
  output logic [BYTES*8-1:0]         word_o,
  output logic [$clog2(BYTES)-1:0]   cnt_o,
  output logic                       complete_o
);

  localparam int CW = $clog2(BYTES);

  // Only BYTES-1 bytes are stored; the final byte is taken straight from
  // the input when the group completes.
  logic [(BYTES-1)*8-1:0] sreg_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      // A byte shifted together with a clear starts the new group.
      cnt_d = shift_i ? CW'(1) : '0;
    end else if (shift_i) begin
      cnt_d = cnt_q + 1'b1;  // wraps to 0 on the last byte of a group
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (shift_i) begin
        sreg_q <= {sreg_q[(BYTES-2)*8-1:0], byte_i};
      end
    end
  end

  assign word_o     = {sreg_q, byte_i};
  assign cnt_o      = cnt_q;
  assign complete_o = shift_i && !clear_i && (cnt_q == CW'(BYTES-1));

endmodule : byte_packer
`default_nettype wire

// File: rtl/cipher_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cipher_stream_ctrl
// Purpose  : Byte-stream front/back end for the Twofish datapath core.
//            Packs key and block bytes into 128-bit words, launches the
//            core with the Start/busy handshake, captures the result and
//            streams it out as 16 bytes.
// Ports    : clk_i / rst_i            - clock, async active-high reset
//            in_data_i, in_is_key_i,
//            in_ende_i, in_valid_i,
//            in_ready_o               - input byte stream
//            out_data_o, out_valid_o,
//            out_ready_i, out_last_o  - result byte stream
//            core_block_o, core_key_o,
//            core_start_o, core_ende_o,
//            core_o_i, core_busy_i    - datapath core interface
//            key_valid_o              - a full key is loaded
//            err_seq_o                - one-cycle sequencing error pulse
//            err_timeout_o            - sticky core timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module cipher_stream_ctrl #(
  parameter int BLOCK_BYTES  = 16,  // fixed by the core; only 16 is legal
  parameter int CORE_TIMEOUT = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [7:0]                 in_data_i,
  input  logic                       in_is_key_i,
  input  logic                       in_ende_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [7:0]                 out_data_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic                       out_last_o,
  output logic [BLOCK_BYTES*8-1:0]   core_block_o,
  output logic [BLOCK_BYTES*8-1:0]   core_key_o,
  output logic                       core_start_o,
  output logic                       core_ende_o,
  input  logic [BLOCK_BYTES*8-1:0]   core_o_i,
  input  logic                       core_busy_i,
  output logic                       key_valid_o,
  output logic                       err_seq_o,
  output logic                       err_timeout_o
);

  import cipher_pkg::*;

  localparam int W  = KEY_BITS;
  localparam int CW = $clog2(BLOCK_BYTES);
  localparam int TW = $clog2(CORE_TIMEOUT) + 1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  ctrl_state_t   state_q, state_d;
  logic          rdy_en_q;            // holds in_ready low for the first cycle out of reset
  logic          key_valid_q, key_valid_d;
  logic [W-1:0]  core_key_q, core_key_d;
  logic [W-1:0]  core_block_q, core_block_d;
  logic          ende_q, ende_d;
  logic          err_seq_q;
  logic          err_timeout_q, err_timeout_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [W-1:0]  osreg_q, osreg_d;
  logic [CW-1:0] ocnt_q, ocnt_d;

  // --------------------------------------------------------------------------
  // Input acceptance and sequencing checks
  // --------------------------------------------------------------------------
  logic          accept;
  logic          no_key_err;
  logic          switch_err;
  logic          seq_err;
  logic          key_shift;
  logic          blk_shift;
  logic [W-1:0]  key_word;
  logic [W-1:0]  blk_word;
  logic [CW-1:0] key_cnt;
  logic [CW-1:0] blk_cnt;
  logic          key_done;
  logic          blk_done;

  assign accept     = (state_q == FILL) && rdy_en_q && in_valid_i;
  // Block bytes are meaningless without a key: drop them.
  assign no_key_err = accept && !in_is_key_i && !key_valid_q;
  // A group of the other kind is partially loaded: the byte restarts a group.
  assign switch_err = accept && !no_key_err &&
                      (in_is_key_i ? (blk_cnt != '0) : (key_cnt != '0));
  assign seq_err    = no_key_err || switch_err;
  assign key_shift  = accept && in_is_key_i;
  assign blk_shift  = accept && !in_is_key_i && key_valid_q;

  byte_packer #(.BYTES(BLOCK_BYTES)) u_key_packer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (seq_err),
    .shift_i    (key_shift),
    .byte_i     (in_data_i),
    .word_o     (key_word),
    .cnt_o      (key_cnt),
    .complete_o (key_done)
  );

  byte_packer #(.BYTES(BLOCK_BYTES)) u_blk_packer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (seq_err),
    .shift_i    (blk_shift),
    .byte_i     (in_data_i),
    .word_o     (blk_word),
    .cnt_o      (blk_cnt),
    .complete_o (blk_done)
  );

  // --------------------------------------------------------------------------
  // FSM next-state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    key_valid_d   = key_valid_q;
    core_key_d    = core_key_q;
    core_block_d  = core_block_q;
    ende_d        = ende_q;
    err_timeout_d = err_timeout_q;
    tmo_d         = tmo_q;
    osreg_d       = osreg_q;
    ocnt_d        = ocnt_q;
    in_ready_o    = 1'b0;
    core_start_o  = 1'b0;
    out_valid_o   = 1'b0;
    out_last_o    = 1'b0;

    case (state_q)
      FILL: begin
        in_ready_o = rdy_en_q;
        // The old key stays on the core until a new group fully arrives.
        if (key_done) begin
          core_key_d  = key_word;
          key_valid_d = 1'b1;
        end
        if (blk_shift && (blk_cnt == '0)) begin
          ende_d = in_ende_i;
        end
        if (blk_done) begin
          core_block_d = blk_word;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        // Start is held until the core acknowledges with busy; the core
        // needs Start low again to finish.
        core_start_o = 1'b1;
        if (core_busy_i) begin
          tmo_d   = '0;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (!core_busy_i) begin
          osreg_d = core_o_i;
          ocnt_d  = '0;
          state_d = DRAIN;
        end else if (tmo_q == TW'(CORE_TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = FILL;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      DRAIN: begin
        out_valid_o = 1'b1;
        out_last_o  = (ocnt_q == CW'(BLOCK_BYTES - 1));
        if (out_ready_i) begin
          osreg_d = {osreg_q[W-9:0], 8'h00};
          ocnt_d  = ocnt_q + 1'b1;
          if (ocnt_q == CW'(BLOCK_BYTES - 1)) begin
            state_d = FILL;
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= FILL;
      rdy_en_q      <= 1'b0;
      key_valid_q   <= 1'b0;
      core_key_q    <= '0;
      core_block_q  <= '0;
      ende_q        <= 1'b0;
      err_seq_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      tmo_q         <= '0;
      osreg_q       <= '0;
      ocnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      rdy_en_q      <= 1'b1;
      key_valid_q   <= key_valid_d;
      core_key_q    <= core_key_d;
      core_block_q  <= core_block_d;
      ende_q        <= ende_d;
      err_seq_q     <= seq_err;
      err_timeout_q <= err_timeout_d;
      tmo_q         <= tmo_d;
      osreg_q       <= osreg_d;
      ocnt_q        <= ocnt_d;
    end
  end

  assign out_data_o    = osreg_q[W-1:W-8];
  assign core_key_o    = core_key_q;
  assign core_block_o  = core_block_q;
  assign core_ende_o   = ende_q;
  assign key_valid_o   = key_valid_q;
  assign err_seq_o     = err_seq_q;
  assign err_timeout_o = err_timeout_q;

endmodule : cipher_stream_ctrl
`default_nettype wire

// File: tb/tb_cipher_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cipher_stream_ctrl
// Purpose  : Self-checking bench for cipher_stream_ctrl. A stub core answers
//            the Start/busy handshake from a table of known Twofish vectors;
//            expected output bytes are queued at stimulus time and a monitor
//            compares each delivered byte.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cipher_stream_ctrl;

  localparam logic [127:0] CT0 = 128'h9F589F5CF6122C32B6BFEC2F2AE8C35A;
  localparam logic [127:0] K1  = 128'h000102030405060708090A0B0C0D0E0F;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_data = '0;
  logic         in_is_key = 1'b0;
  logic         in_ende = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_last;
  logic [127:0] core_block;
  logic [127:0] core_key;
  logic         core_start;
  logic         core_ende;
  logic [127:0] core_o;
  logic         core_busy;
  logic         key_valid;
  logic         err_seq;
  logic         err_timeout;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  cipher_stream_ctrl #(.BLOCK_BYTES(16), .CORE_TIMEOUT(64)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_data_i    (in_data),
    .in_is_key_i  (in_is_key),
    .in_ende_i    (in_ende),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .out_data_o   (out_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_last_o   (out_last),
    .core_block_o (core_block),
    .core_key_o   (core_key),
    .core_start_o (core_start),
    .core_ende_o  (core_ende),
    .core_o_i     (core_o),
    .core_busy_i  (core_busy),
    .key_valid_o  (key_valid),
    .err_seq_o    (err_seq),
    .err_timeout_o(err_timeout)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Stub core: known-answer table, busy for a few cycles after Start drops.
  // --------------------------------------------------------------------------
  logic         stub_hang = 1'b0;
  logic         stub_st;
  int           stub_cnt;
  logic [127:0] stub_res;

  function automatic logic [127:0] core_model(input logic [127:0] k, input logic [127:0] b,
                                              input logic e);
    if (k == '0 && b == '0 && !e) return CT0;
    if (k == '0 && b == CT0 && e) return '0;
    return 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_busy <= 1'b0;
      core_o    <= '0;
      stub_st   <= 1'b0;
      stub_cnt  <= 0;
      stub_res  <= '0;
    end else if (!stub_st) begin
      if (core_start) begin
        core_busy <= 1'b1;
        stub_st   <= 1'b1;
        stub_cnt  <= 0;
        stub_res  <= core_model(core_key, core_block, core_ende);
      end
    end else if (!core_start && !stub_hang) begin
      if (stub_cnt == 3) begin
        core_busy <= 1'b0;
        core_o    <= stub_res;
        stub_st   <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt + 1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output monitor
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %h want no output", out_data);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_last", out_last, e.last);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b, input logic k, input logic e);
    in_data   = b;
    in_is_key = k;
    in_ende   = e;
    in_valid  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL in_handshake: in_ready low for 200 cycles, want 1");
    in_valid = 1'b0;
  endtask

  task automatic send_group(input logic [127:0] v, input logic k, input logic e, input int n);
    for (int i = 0; i < n; i++) send_byte(v[127-8*i -: 8], k, e);
  endtask

  task automatic push_expected(input logic [127:0] v);
    for (int i = 0; i < 16; i++) begin
      beat_t b;
      b.data = v[127-8*i -: 8];
      b.last = (i == 15);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_done", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Directed tests
  // --------------------------------------------------------------------------
  initial begin
    int n;
    logic [7:0] held;

    // 1: reset values, then encrypt of all-zero key/block
    do_reset();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_ende", core_ende, 0);
    check("rst_core_key", core_key, 0);
    check("rst_core_block", core_block, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_err_seq", err_seq, 0);
    check("rst_err_timeout", err_timeout, 0);
    rst = 1'b0;

    send_group('0, 1'b1, 1'b0, 16);
    check("t1_key_valid", key_valid, 1);
    push_expected(CT0);
    send_group('0, 1'b0, 1'b0, 16);
    check("t1_start_latency", core_start, 1);
    check("t1_in_ready_issue", in_ready, 0);
    wait_empty();
    check("t1_in_ready_fill", in_ready, 1);

    // 2: decrypt back to zeros
    push_expected('0);
    send_group(CT0, 1'b0, 1'b1, 16);
    check("t2_core_ende", core_ende, 1);
    check("t2_core_block", core_block, CT0);
    wait_empty();

    // 3: sequencing errors
    do_reset();
    rst = 1'b0;
    send_group(K1, 1'b1, 1'b0, 8);
    send_byte(8'hAA, 1'b0, 1'b0);
    check("t3_err_seq_nokey", err_seq, 1);
    check("t3_key_valid_low", key_valid, 0);
    @(posedge clk);
    #1;
    check("t3_err_seq_pulse", err_seq, 0);
    send_group(K1, 1'b1, 1'b0, 15);
    check("t3_key_valid_15", key_valid, 0);
    send_byte(K1[7:0], 1'b1, 1'b0);
    check("t3_key_valid_16", key_valid, 1);
    check("t3_core_key", core_key, K1);
    send_group(CT0, 1'b0, 1'b0, 3);
    send_byte(8'h00, 1'b1, 1'b0);
    check("t3_err_seq_switch", err_seq, 1);
    send_group('0, 1'b1, 1'b0, 14);
    check("t3_old_key_held", core_key, K1);
    send_byte(8'h00, 1'b1, 1'b0);
    check("t3_new_key", core_key, 0);
    check("t3_no_issue", in_ready, 1);

    // 4: backpressure mid-drain
    push_expected(CT0);
    send_group('0, 1'b0, 1'b0, 16);
    n = 0;
    while (exp_q.size() > 10 && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    held = exp_q[0].data;
    repeat (5) begin
      @(negedge clk);
      check("t4_stall_valid", out_valid, 1);
      check("t4_stall_data", out_data, held);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_empty();

    // 5: core never finishes
    stub_hang = 1'b1;
    send_group('0, 1'b0, 1'b0, 16);
    n = 0;
    while (core_start && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    n = 0;
    while (!err_timeout && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t5_timeout_cycles", n, 64);
    check("t5_in_ready", in_ready, 1);
    check("t5_out_valid", out_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t5_sticky", err_timeout, 1);

    // 6: reset during WAIT, then a clean run
    stub_hang = 1'b0;
    do_reset();
    rst = 1'b0;
    send_group('0, 1'b1, 1'b0, 16);
    send_group('0, 1'b0, 1'b0, 16);
    n = 0;
    while (core_start && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6_core_start", core_start, 0);
    check("t6_key_valid", key_valid, 0);
    check("t6_in_ready", in_ready, 0);
    check("t6_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_group('0, 1'b1, 1'b0, 16);
    push_expected(CT0);
    send_group('0, 1'b0, 1'b0, 16);
    wait_empty();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cipher_stream_ctrl
`default_nettype wire
